cordic_atan2: RTL and testbench
===============================

Name: cordic_atan2

Overview:
Iterative, multi-cycle CORDIC engine in vectoring mode that computes the four-quadrant arctangent atan2(y, x) of two signed fixed-point inputs. The output angle is in binary angle units: a full turn is 2^WIDTH, so +pi is 2^(WIDTH-1) and wraps to -2^(WIDTH-1). It sits as a self-contained arithmetic unit behind a start/ready/done handshake and uses one add/shift datapath over ITERATIONS cycles.

Parameters:
WIDTH, 32, bit width of x, y and angle (two's complement).
ITERATIONS, 30, number of CORDIC micro-rotations (must be <= WIDTH-2).
GUARD, 2, extra MSBs on the internal x/y registers to absorb CORDIC gain (~1.647) and negation of the most negative input.

Ports:
clk  input  1  single clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  request; sampled only while ready=1.
x  input  WIDTH  signed abscissa.
y  input  WIDTH  signed ordinate.
ready  output  1  high in IDLE; a new request is accepted.
done  output  1  high while the result is valid, held until start is deasserted.
angle  output  WIDTH  signed binary-angle result, atan2(y,x)*2^(WIDTH-1)/pi.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ready=1, done=0, angle=0, internal x/y/z/iteration counter cleared. Reset mid-computation aborts with no result.
- States: IDLE -> BUSY -> DONE -> IDLE.
- IDLE: ready=1, done=0. On clock edge with start=1: sign-extend x,y to WIDTH+GUARD, apply quadrant pre-rotation, counter i=0, go to BUSY.
- Pre-rotation: if x>=0, load (x,y), z=0. If x<0 and y>=0, load (y,-x), z=+2^(WIDTH-2). If x<0 and y<0, load (-y,x), z=-2^(WIDTH-2).
- BUSY: ready=0, done=0. Each cycle, if y>=0: x+=y>>>i, y-=x>>>i, z+=ATAN[i]. Otherwise: x-=y>>>i, y+=x>>>i, z-=ATAN[i]. All updates use old values, with arithmetic shifts and i incremented. After iteration ITERATIONS-1, register angle=z[WIDTH-1:0] and go to DONE.
- Latency: done rises ITERATIONS+1 rising edges after the edge that accepted start (31 for defaults).
- ATAN[i] = round(atan(2^-i) * 2^(WIDTH-1)/pi). ATAN[0] = 2^(WIDTH-3).
- z arithmetic wraps modulo 2^WIDTH. The angle for x<0, y=0 may come out as -2^(WIDTH-1) (i.e. +pi wrapped); either sign of pi is correct.
- DONE: done=1, ready=0, angle stable. Stay while start=1. When start=0, go to IDLE on the next edge, so done falls one cycle after start falls.
- angle holds its value in IDLE until the next result is written.
- x=y=0: result is 0 (y>=0 path drives z to about 0 ± table residue); |angle| <= 2^(WIDTH-8) is acceptable.
- Accuracy for nonzero inputs with max(|x|,|y|) >= 2^16: |angle - ideal| <= 64 LSB.
- No output scaling for gain; magnitude is not an output.

Decomposition:
- Package cordic_pkg: WIDTH/ITERATIONS defaults, the state enum (IDLE, BUSY, DONE), and the ATAN table as a constant function or localparam array generated for WIDTH.
- One natural sub-module: cordic_atan_lut, a combinational table indexed by i that returns ATAN[i].
- The iteration datapath stays in cordic_atan2.

Test Plan:
- Reset held low, then released: ready=1, done=0, angle=0. Start=1 during reset is ignored.
- (0, 2^30) -> angle ≈ 1073741824; (2^30, 2^30) -> ≈ 536870912; (2^30, 0) -> ≈ 0. Each within ±64, with done rising exactly 31 cycles after acceptance.
- (2^30, -2^30) -> ≈ -536870912; (0, -2^30) -> ≈ -1073741824; (-2^30, -2^30) -> ≈ -1610612736.
- (-2^30, 0) -> ≈ ±2147483648 (modular); (-2^30, 2^30) -> ≈ +1610612736. Also test the extremes (-2^31, -2^31) -> ≈ -1610612736 with no overflow.
- Handshake: keep start high after done -> done stays high and angle stable; drop start -> done low next cycle, ready high. Changing x/y during BUSY does not affect the result.
- Assert reset mid-BUSY -> immediate IDLE, done=0, angle=0. The next request computes correctly.

Source files
------------

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared defaults, FSM state type and arctangent table for the CORDIC atan2 engine.
package cordic_pkg;

    localparam int CORDIC_WIDTH      = 32;
    localparam int CORDIC_ITERATIONS = 30;
    localparam int CORDIC_GUARD      = 2;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // round(atan(2^-i) * 2^31 / pi); rescaled to other widths by atan_entry
    localparam logic [31:0] ATAN32 [0:31] = '{
        32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
        32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
        32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
        32'd166886,    32'd83443,     32'd41722,     32'd20861,
        32'd10430,     32'd5215,      32'd2608,      32'd1304,
        32'd652,       32'd326,       32'd163,       32'd81,
        32'd41,        32'd20,        32'd10,        32'd5,
        32'd3,         32'd1,         32'd0,         32'd0
    };

    function automatic logic [63:0] atan_entry(input int i, input int w);
        logic [63:0] v;
        v = (i >= 0 && i < 32) ? {32'd0, ATAN32[i]} : 64'd0;
        if (w >= 32) return v << (w - 32);
        return (v + (64'd1 << (31 - w))) >> (32 - w);
    endfunction

endpackage

// File: rtl/cordic_atan_lut.sv
// cordic_atan_lut: combinational arctangent table, ATAN[idx] in binary angle units.
module cordic_atan_lut
    import cordic_pkg::*;
#(
    parameter int WIDTH = CORDIC_WIDTH,
    parameter int IW    = 5
) (
    input  logic [IW-1:0]    idx,
    output logic [WIDTH-1:0] atan
);

    always_comb atan = WIDTH'(atan_entry(int'(idx), WIDTH));

endmodule

// File: rtl/cordic_atan2.sv
// cordic_atan2: iterative vectoring-mode CORDIC computing atan2(y, x) as a binary angle
// behind a start/ready/done handshake.
module cordic_atan2
    import cordic_pkg::*;
#(
    parameter int WIDTH      = CORDIC_WIDTH,
    parameter int ITERATIONS = CORDIC_ITERATIONS,
    parameter int GUARD      = CORDIC_GUARD
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] y,
    output logic                    ready,
    output logic                    done,
    output logic signed [WIDTH-1:0] angle
);

    localparam int XW = WIDTH + GUARD;
    localparam int IW = $clog2(ITERATIONS + 1);
    localparam logic [WIDTH-1:0] QUARTER = {2'b01, {(WIDTH-2){1'b0}}};

    state_t                 state;
    logic signed [XW-1:0]   xr, yr;
    logic        [WIDTH-1:0] zr;
    logic        [IW-1:0]   i;
    logic                   zero;

    logic signed [XW-1:0]   xe, ye, x0, y0, xn, yn;
    logic        [WIDTH-1:0] z0, zn, step;
    logic                   pos;

    cordic_atan_lut #(.WIDTH(WIDTH), .IW(IW)) u_lut (.idx(i), .atan(step));

    // Left half-plane inputs are rotated by +/-90 degrees so the micro-rotations converge
    always_comb begin
        xe  = {{GUARD{x[WIDTH-1]}}, x};
        ye  = {{GUARD{y[WIDTH-1]}}, y};
        x0  = !x[WIDTH-1] ? xe : (!y[WIDTH-1] ? ye : -ye);
        y0  = !x[WIDTH-1] ? ye : (!y[WIDTH-1] ? -xe : xe);
        z0  = !x[WIDTH-1] ? '0 : (!y[WIDTH-1] ? QUARTER : -QUARTER);
        pos = !yr[XW-1];
        xn  = pos ? xr + (yr >>> i) : xr - (yr >>> i);
        yn  = pos ? yr - (xr >>> i) : yr + (xr >>> i);
        zn  = pos ? zr + step : zr - step;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ready <= 1'b1;
            done  <= 1'b0;
            angle <= '0;
            xr    <= '0;
            yr    <= '0;
            zr    <= '0;
            i     <= '0;
            zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    xr    <= x0;
                    yr    <= y0;
                    zr    <= z0;
                    i     <= '0;
                    zero  <= (x == '0) && (y == '0);
                    ready <= 1'b0;
                    state <= BUSY;
                end
                BUSY: if (i == IW'(ITERATIONS)) begin
                    // The origin has no direction; report 0 rather than the table sum
                    angle <= zero ? '0 : zr;
                    done  <= 1'b1;
                    state <= DONE;
                end else begin
                    xr <= xn;
                    yr <= yn;
                    zr <= zn;
                    i  <= i + 1'b1;
                end
                DONE: if (!start) begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_atan2.sv
// tb_cordic_atan2: directed and random atan2 requests checked against a real-arithmetic model.
module tb_cordic_atan2;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b1;
    logic signed [31:0] x = '0;
    logic signed [31:0] y = '0;
    logic               ready, done;
    logic signed [31:0] angle;
    int                 checks = 0;
    int                 fails = 0;

    localparam longint TOL = 64;
    localparam int     P30 = 32'sh4000_0000;
    localparam int     M30 = -32'sh4000_0000;
    localparam int     M31 = 32'sh8000_0000;

    always #5 clk = ~clk;

    cordic_atan2 dut (
        .clk(clk), .reset(reset), .start(start), .x(x), .y(y),
        .ready(ready), .done(done), .angle(angle)
    );

    // Angle differences are taken modulo 2^32 so +pi and -pi compare equal
    task automatic check(input string tag, input longint got, input longint exp, input longint tol);
        logic signed [31:0] d;
        longint             a;
        d = 32'(got - exp);
        a = d < 0 ? -longint'(d) : longint'(d);
        checks++;
        if (a > tol) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic longint ideal(input int xi, input int yi);
        real a;
        a = $atan2(real'(yi), real'(xi));
        return longint'(a / 3.14159265358979323846 * 2147483648.0);
    endfunction

    task automatic run(input string tag, input int xi, input int yi, input longint tol, input bit hold);
        longint exp;
        int     n;
        exp = ideal(xi, yi);
        @(negedge clk);
        check({tag, "/ready"}, longint'(ready), 1, 0);
        x = xi;
        y = yi;
        start = 1'b1;
        @(posedge clk);
        #1;
        x = $urandom;
        y = $urandom;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "/latency"}, n, 31, 0);
        check({tag, "/angle"}, longint'(angle), exp, tol);
        if (hold) begin
            repeat (3) @(posedge clk);
            #1;
            check({tag, "/hold_done"}, longint'(done), 1, 0);
            check({tag, "/hold_angle"}, longint'(angle), exp, tol);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "/done_fall"}, longint'(done), 0, 0);
        check({tag, "/ready_back"}, longint'(ready), 1, 0);
        check({tag, "/idle_angle"}, longint'(angle), exp, tol);
    endtask

    function automatic longint mag(input int v);
        return v < 0 ? -longint'(v) : longint'(v);
    endfunction

    initial begin
        int rx, ry;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", longint'(ready), 1, 0);
        check("rst_done", longint'(done), 0, 0);
        check("rst_angle", longint'(angle), 0, 0);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready", longint'(ready), 1, 0);
        check("post_rst_done", longint'(done), 0, 0);

        run("y_axis",   0,   P30, TOL, 1'b1);
        run("q1_diag",  P30, P30, TOL, 1'b0);
        run("x_axis",   P30, 0,   TOL, 1'b0);
        run("q4_diag",  P30, M30, TOL, 1'b0);
        run("neg_y",    0,   M30, TOL, 1'b0);
        run("q3_diag",  M30, M30, TOL, 1'b1);
        run("neg_x",    M30, 0,   TOL, 1'b0);
        run("q2_diag",  M30, P30, TOL, 1'b0);
        run("extreme",  M31, M31, TOL, 1'b0);
        run("origin",   0,   0,   longint'(1) << 24, 1'b0);

        @(negedge clk);
        x = P30;
        y = P30;
        start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("abort_ready", longint'(ready), 1, 0);
        check("abort_done", longint'(done), 0, 0);
        check("abort_angle", longint'(angle), 0, 0);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        run("after_abort", M30, P30, TOL, 1'b0);

        for (int k = 0; k < 30; k++) begin
            do begin
                rx = $urandom;
                ry = $urandom;
                if (k % 3 == 0) rx = rx >>> $urandom_range(0, 10);
            end while ((mag(rx) > mag(ry) ? mag(rx) : mag(ry)) < (longint'(1) << 20));
            run($sformatf("rnd%0d", k), rx, ry, TOL, k % 7 == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
